// File: rtl/wrf_channel_drain.sv
// Drains the out-of-order write-response channel into a DEPTH-entry FIFO and presents it as a valid/ready stream.
// An entry returned in cycle N is visible in N+1. Reads only go out against free credit, so stalls never drop data.
module wrf_channel_drain #(
   parameter int HDR_WIDTH  = 80,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [HDR_WIDTH-1:0]  ch_meta,
   input  logic [DATA_WIDTH-1:0] ch_data,
   input  logic                  ch_valid,
   input  logic                  ch_empty,
   output logic                  ch_read_en,
   output logic [HDR_WIDTH-1:0]  out_meta,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  count_delivered,
   output logic                  spurious_err,
   output logic                  drained
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [HDR_WIDTH-1:0]  meta_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

   logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]        occ_q, occ_d, inflight_q, inflight_d;
   logic [CW-1:0]        credit;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 spur_q, spur_d;
   logic                 push, pop;

   assign out_valid = (occ_q != '0);

   always_comb begin
      credit     = DEPTH_C - occ_q - inflight_q;
      ch_read_en = ~rst & ~ch_empty & (credit != '0);
      // a return with nothing outstanding is dropped, never written
      push       = ch_valid & (inflight_q != '0);
      pop        = out_valid & out_ready;

      inflight_d = inflight_q + CW'(ch_read_en) - CW'(push);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      tail_d     = tail_q + PW'(push);
      head_d     = head_q + PW'(pop);
      cnt_d      = cnt_q + CNT_WIDTH'(pop);
      spur_d     = spur_q | (ch_valid & (inflight_q == '0));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         meta_mem_q[tail_q] <= ch_meta;
         data_mem_q[tail_q] <= ch_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         inflight_q <= '0;
         cnt_q      <= '0;
         spur_q     <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         spur_q     <= spur_d;
      end
   end

   // gating with out_valid keeps the outputs at zero while storage is still unwritten
   assign out_meta        = out_valid ? meta_mem_q[head_q] : '0;
   assign out_data        = out_valid ? data_mem_q[head_q] : '0;
   assign count_delivered = cnt_q;
   assign spurious_err    = spur_q;
   assign drained         = (occ_q == '0) & (inflight_q == '0) & ch_empty;

endmodule

// File: tb/tb_wrf_channel_drain.sv
// Directed bench for wrf_channel_drain: a latency-configurable channel model feeds the DUT while a reference queue checks order.
module tb_wrf_channel_drain;
   localparam int HW    = 80;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CNTW  = 4;

   logic          clk;
   logic          rst;
   logic [HW-1:0] ch_meta;
   logic [DW-1:0] ch_data;
   logic          ch_valid;
   logic          ch_empty;
   logic          ch_read_en;
   logic [HW-1:0] out_meta;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CNTW-1:0] count_delivered;
   logic          spurious_err;
   logic          drained;

   wrf_channel_drain #(
      .HDR_WIDTH (HW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .CNT_WIDTH (CNTW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ch_meta        (ch_meta),
      .ch_data        (ch_data),
      .ch_valid       (ch_valid),
      .ch_empty       (ch_empty),
      .ch_read_en     (ch_read_en),
      .out_meta       (out_meta),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count_delivered(count_delivered),
      .spurious_err   (spurious_err),
      .drained        (drained)
   );

   typedef struct {
      int            due;
      logic [HW-1:0] m;
   } ret_t;

   logic [HW-1:0] chq[$];
   logic [HW-1:0] refq[$];
   ret_t          retq[$];

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc_n = 0;
   int   lat = 1;
   int   mocc = 0;
   int   minf = 0;
   bit   spur_m = 0;
   int   n_deliv = 0;
   int   rd_pulses = 0;
   int   first_rd = -1;
   int   last_rd = -1;
   int   first_pop = -1;
   int   last_pop = -1;
   logic rdy = 1'b0;
   bit   inj_vld = 0;
   logic [HW-1:0] inj_meta = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] dat_of(input logic [HW-1:0] m);
      return m[DW-1:0] ^ 64'hDEAD_BEEF_0BAD_F00D;
   endfunction

   task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_trackers();
      rd_pulses = 0;
      first_rd  = -1;
      last_rd   = -1;
      first_pop = -1;
      last_pop  = -1;
   endtask

   // one clock cycle, entered and left at a falling edge
   task automatic tick();
      ret_t          r;
      logic [HW-1:0] e;
      bit            exp_rd, push_m, pop_m;
      ch_valid = 1'b0;
      ch_meta  = '0;
      ch_data  = '0;
      if (inj_vld) begin
         ch_valid = 1'b1;
         ch_meta  = inj_meta;
         ch_data  = dat_of(inj_meta);
         inj_vld  = 0;
      end else if (retq.size() > 0 && retq[0].due <= cyc_n) begin
         r        = retq.pop_front();
         ch_valid = 1'b1;
         ch_meta  = r.m;
         ch_data  = dat_of(r.m);
      end
      ch_empty  = (chq.size() == 0);
      out_ready = rdy;
      #1;
      exp_rd = !ch_empty && (DEPTH - mocc - minf != 0);
      chk("rd_en", ch_read_en, exp_rd);
      chk("out_valid", out_valid, mocc != 0);
      chk("spurious", spurious_err, spur_m);
      chk("drained", drained, mocc == 0 && minf == 0 && ch_empty);
      chk("count", count_delivered, n_deliv % (1 << CNTW));
      if (out_valid) begin
         chk("out_has_ref", refq.size() != 0, 1);
         if (refq.size() != 0) begin
            chk("head_meta", out_meta, refq[0]);
            chk("head_data", out_data, dat_of(refq[0]));
         end
      end
      push_m = ch_valid && (minf != 0);
      if (ch_valid && minf == 0) spur_m = 1;
      pop_m = out_valid && out_ready;
      if (pop_m) begin
         if (refq.size() != 0) e = refq.pop_front();
         n_deliv++;
         if (first_pop < 0) first_pop = cyc_n;
         last_pop = cyc_n;
      end
      if (ch_read_en) begin
         chk("rd_chq_nonempty", chq.size() != 0, 1);
         if (chq.size() != 0) begin
            e     = chq.pop_front();
            r.due = cyc_n + lat;
            r.m   = e;
            retq.push_back(r);
            refq.push_back(e);
         end
         rd_pulses++;
         if (first_rd < 0) first_rd = cyc_n;
         last_rd = cyc_n;
      end
      minf = minf + int'(ch_read_en) - int'(push_m);
      mocc = mocc + int'(push_m) - int'(pop_m);
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic run_idle(input int budget, input bit toggle);
      int i;
      i = 0;
      while (!(chq.size() == 0 && retq.size() == 0 && refq.size() == 0) && i < budget) begin
         if (toggle) rdy = (i % 3 != 0);
         tick();
         i++;
      end
      chk("idle_reached", chq.size() == 0 && retq.size() == 0 && refq.size() == 0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      ch_meta   = '0;
      ch_data   = '0;
      ch_valid  = 1'b0;
      ch_empty  = 1'b1;
      out_ready = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_en", ch_read_en, 0);
      chk("rst_count", count_delivered, 0);
      chk("rst_spur", spurious_err, 0);
      chk("rst_meta", out_meta, 0);
      chk("rst_data", out_data, 0);
      chk("rst_drained_hi", drained, 1);
      ch_empty = 1'b0;
      #1;
      chk("rst_rd_forced", ch_read_en, 0);
      chk("rst_drained_lo", drained, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // streaming: 8 entries, ready held high
      for (int i = 1; i <= 8; i++) chq.push_back(HW'(i));
      rdy = 1'b1;
      reset_trackers();
      run_idle(60, 0);
      chk("stream_reads", rd_pulses, 8);
      chk("stream_rd_span", last_rd - first_rd, 7);
      chk("stream_pop_span", last_pop - first_pop, 7);
      chk("stream_latency", first_pop - first_rd, 2);
      chk("stream_count", count_delivered, 8);
      chk("stream_drained", drained, 1);

      // spurious return with nothing outstanding
      inj_vld  = 1;
      inj_meta = 80'hAA;
      tick();
      tick();
      tick();
      chk("spur_set", spurious_err, 1);
      chk("spur_no_out", out_valid, 0);
      chk("spur_count", count_delivered, 8);

      // backpressure: 10 entries, ready low
      reset_trackers();
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) chq.push_back(HW'(16 + i));
      repeat (10) tick();
      chk("bp_reads", rd_pulses, 4);
      chk("bp_rd_low", ch_read_en, 0);
      chk("bp_head", out_meta, 80'h10);
      rdy = 1'b1;
      run_idle(80, 0);
      chk("bp_count", count_delivered, 2);

      // reset while occ=3, inflight=1
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) chq.push_back(HW'(32 + i));
      repeat (4) tick();
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_rd_en", ch_read_en, 0);
      chk("mid_rst_count", count_delivered, 0);
      chk("mid_rst_spur", spurious_err, 0);
      chk("mid_rst_meta", out_meta, 0);
      chq.delete();
      retq.delete();
      refq.delete();
      mocc    = 0;
      minf    = 0;
      spur_m  = 0;
      n_deliv = 0;
      @(negedge clk);
      rst = 1'b0;
      inj_vld  = 1;
      inj_meta = 80'hAA;
      tick();
      tick();
      chk("post_rst_spur", spurious_err, 1);

      // full buffer with two-cycle channel latency, then push/pop at full and wrap of the counter
      lat = 2;
      reset_trackers();
      rdy = 1'b0;
      for (int i = 0; i < 17; i++) chq.push_back(HW'(48 + i));
      repeat (8) tick();
      chk("full_reads", rd_pulses, 4);
      chk("full_head", out_meta, 80'h30);
      rdy = 1'b1;
      repeat (10) tick();
      run_idle(200, 1);
      chk("wrap_count", count_delivered, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
